register_dump: RTL

- Debug and verification reader for the datapath register file.
- On request, walks every register index through one register-file read port and captures each value.
- Streams {index, data} beats out over a valid/ready interface, with a running XOR checksum.
- Sits beside the register file; the datapath uses busy to stall writeback if a consistent snapshot is required.

---
 rtl/register_dump_pkg.sv | 22 ++
 rtl/register_dump.sv | 115 +++++++++++
 2 files changed

// File: rtl/register_dump_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : register_dump_pkg
// Brief   : Datapath constants and dump-walker state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package register_dump_pkg;

    localparam int NUM_REGS = 32;
    localparam int IDX_W    = 5;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/register_dump.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : register_dump
// Brief   : Walks every register-file index through one read port and streams
//           {index, data} beats with a running XOR checksum.
// Revision: 1.0 - initial release
// ============================================================================
module register_dump #(
    parameter int NUM_REGS  = register_dump_pkg::NUM_REGS,
    parameter int IDX_W     = register_dump_pkg::IDX_W,
    parameter int DATA_W    = register_dump_pkg::DATA_W,
    parameter int SKIP_ZERO = 0
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              start,
    input  logic              abort,
    output logic [IDX_W-1:0]  read_index,
    input  logic [DATA_W-1:0] read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    import register_dump_pkg::*;

    localparam logic [IDX_W-1:0] c_first_idx = (SKIP_ZERO != 0) ? IDX_W'(1) : '0;
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(NUM_REGS - 1);

    dump_state_t       r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_out_valid;
    logic [IDX_W-1:0]  r_out_index;
    logic [DATA_W-1:0] r_out_data;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_checksum;

    // The read port only sees a live index while a fetch is outstanding.
    assign read_index = (r_state == S_FETCH) ? r_idx : '0;
    assign out_valid  = r_out_valid;
    assign out_index  = r_out_index;
    assign out_data   = r_out_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign checksum   = r_checksum;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_idx      <= c_first_idx;
                        r_checksum <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_out_data  <= read_data;
                        r_out_index <= r_idx;
                        r_checksum  <= r_checksum ^ read_data;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Abort outranks a handshake landing in the same cycle.
                    if (abort) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_idx == c_last_idx) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
